// File: rtl/fetch_pkg.sv
// Shared front-end definitions: cache and fetch FSM state encodings plus fetch-unit parameter defaults.
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH    = 64;
    localparam int unsigned FETCH_INSTSIZE = 32;
    localparam int unsigned FETCH_QDEPTH   = 4;
    localparam logic [63:0] FETCH_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        C_IDLE,
        C_LOOKUP,
        C_REFILL
    } cache_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_FULL,
        F_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, i-cache request/response and decode-side queue head.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int WIDTH    = FETCH_WIDTH,
    parameter int INSTSIZE = FETCH_INSTSIZE
);
    logic                redirect_valid;
    logic [WIDTH-1:0]    redirect_pc;
    logic                ic_req;
    logic [WIDTH-1:0]    ic_pc;
    logic                ic_rdy;
    logic [INSTSIZE-1:0] ic_instr;
    logic                dec_valid;
    logic [INSTSIZE-1:0] dec_instr;
    logic [WIDTH-1:0]    dec_pc;
    logic                dec_ready;

    modport master (
        input  redirect_valid, redirect_pc, ic_rdy, ic_instr, dec_ready,
        output ic_req, ic_pc, dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, ic_rdy, ic_instr, dec_ready,
        input  ic_req, ic_pc, dec_valid, dec_instr, dec_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular queue of fetched {pc, instr} entries; head is always presented, flush clears pointers and count.
module fetch_queue #(
    parameter int WIDTH    = 64,
    parameter int INSTSIZE = 32,
    parameter int DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_pc,
    input  logic [INSTSIZE-1:0]   push_instr,
    input  logic                  pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                  head_valid,
    output logic [WIDTH-1:0]      head_pc,
    output logic [INSTSIZE-1:0]   head_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0]    mem_pc    [DEPTH];
    logic [INSTSIZE-1:0] mem_instr [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wr_ptr]    <= push_pc;
            mem_instr[wr_ptr] <= push_instr;
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = mem_pc[rd_ptr];
    assign head_instr = mem_instr[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding i-cache request FSM, fetch PC, redirect handling, decode queue.
// F_IDLE post-reset | F_REQ issue request | F_WAIT await response | F_FULL queue full | F_DROP discard stale response
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter int               INSTSIZE = FETCH_INSTSIZE,
    parameter int               QDEPTH   = FETCH_QDEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] LAST_FREE = CW'(QDEPTH - 1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_nxt;
    logic             q_push;
    logic             q_pop;
    logic             q_flush;
    logic [CW-1:0]    q_count;

    assign q_pop = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        q_push       = 1'b0;
        q_flush      = 1'b0;
        if (bus.redirect_valid) begin
            q_flush      = 1'b1;
            fetch_pc_nxt = {bus.redirect_pc[WIDTH-1:2], 2'b00};
            // A response still owed by the i-cache must be swallowed before fetching again.
            if ((state == F_WAIT || state == F_DROP) && !bus.ic_rdy)
                state_nxt = F_DROP;
            else
                state_nxt = F_REQ;
        end else begin
            unique case (state)
                F_IDLE: state_nxt = F_REQ;
                F_REQ:  state_nxt = F_WAIT;
                F_WAIT: begin
                    if (bus.ic_rdy) begin
                        q_push       = 1'b1;
                        fetch_pc_nxt = fetch_pc + WIDTH'(4);
                        state_nxt    = (!q_pop && q_count == LAST_FREE) ? F_FULL : F_REQ;
                    end
                end
                F_FULL: if (q_pop) state_nxt = F_REQ;
                F_DROP: if (bus.ic_rdy) state_nxt = F_REQ;
                default: state_nxt = F_IDLE;
            endcase
        end
    end

    assign bus.ic_req = (state == F_REQ);
    assign bus.ic_pc  = fetch_pc;

    fetch_queue #(
        .WIDTH    (WIDTH),
        .INSTSIZE (INSTSIZE),
        .DEPTH    (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (q_flush),
        .push       (q_push),
        .push_pc    (fetch_pc),
        .push_instr (bus.ic_instr),
        .pop        (q_pop),
        .count      (q_count),
        .head_valid (bus.dec_valid),
        .head_pc    (bus.dec_pc),
        .head_instr (bus.dec_instr)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: WIDTH, 64, address/PC width.
REQ-002 Parameter: INSTSIZE, 32, instruction width.
REQ-003 Parameter: QDEPTH, 4, instruction queue entries (power of two, >=2).
REQ-004 Parameter: RESET_PC, 64'h0, PC loaded at reset.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 redirect_valid  input  1  branch/exception redirect strobe.
REQ-008 redirect_pc  input  WIDTH  redirect target.
REQ-009 ic_req  output  1  one-cycle fetch request pulse to i-cache.
REQ-010 ic_pc  output  WIDTH  fetch address; valid while ic_req=1.
REQ-011 ic_rdy  input  1  i-cache response strobe, one cycle.
REQ-012 ic_instr  input  INSTSIZE  fetched instruction, valid with ic_rdy.
REQ-013 dec_valid  output  1  queue head valid to decode.
REQ-014 dec_instr  output  INSTSIZE  queue head instruction.
REQ-015 dec_pc  output  WIDTH  queue head PC.
REQ-016 dec_ready  input  1  decode accepts head when dec_valid=1.

Function
REQ-017 FSM states SHALL be F_IDLE, F_REQ, F_WAIT, F_FULL, F_DROP.
REQ-018 F_IDLE -> F_REQ next cycle unconditionally.
REQ-019 F_REQ drives ic_req=1, ic_pc=fetch_pc for exactly one cycle, then -> F_WAIT.
REQ-020 At most one request outstanding; no ic_req in F_WAIT, F_FULL, F_DROP.
REQ-021 F_WAIT on ic_rdy: push {fetch_pc, ic_instr} into queue, fetch_pc += 4 (mod 2^WIDTH, wraps), then -> F_FULL if post-push count == QDEPTH, else -> F_REQ.
REQ-022 F_FULL -> F_REQ in the cycle a pop lowers count below QDEPTH.
REQ-023 Pop occurs when dec_valid & dec_ready; dec_valid = (count != 0); dec_* always show head entry.
REQ-024 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-025 Queue write/read pointers wrap modulo QDEPTH; push never occurs when count == QDEPTH.
REQ-026 Response-to-dec_valid latency: ic_rdy in cycle k with empty queue -> dec_valid=1 in cycle k+1.
REQ-027 redirect_valid has priority over push, pop and all state transitions in that cycle.
REQ-028 Redirect: queue flushed (count=0, pointers=0), fetch_pc = {redirect_pc[WIDTH-1:2], 2'b00}.
REQ-029 Redirect in F_WAIT without ic_rdy same cycle -> F_DROP; otherwise -> F_REQ.
REQ-030 Redirect in F_WAIT with ic_rdy same cycle: response discarded, -> F_REQ.
REQ-031 F_DROP: discard next ic_rdy response (no push, no PC update), then -> F_REQ; further redirect in F_DROP updates fetch_pc, stays F_DROP.
REQ-032 Redirect latency: redirect in cycle N (not F_WAIT/F_DROP) -> ic_req with ic_pc=target in cycle N+1.
REQ-033 ic_rdy outside F_WAIT/F_DROP SHALL be ignored.

Reset
REQ-034 Reset SHALL set state=F_IDLE, fetch_pc=RESET_PC, count=0, pointers=0.
REQ-035 Reset outputs: ic_req=0, ic_pc=RESET_PC, dec_valid=0; dec_instr/dec_pc don't-care.
REQ-036 Reset mid-request discards any in-flight response; reset dominates redirect.

Structure
REQ-037 Fetch state enum and parameter defaults in shared package fetch_pkg, alongside existing cache state definitions.
REQ-038 Queue SHALL be sub-module fetch_queue (push/pop/flush, count, head outputs); FSM and PC in fetch_unit.

Verification
REQ-039 Reset then ic_rdy two cycles after each ic_req, dec_ready=1 -> dec_pc 0x0,0x4,0x8 in order, one ic_req outstanding.
REQ-040 dec_ready=0, four responses -> count=4, F_FULL, no ic_req; one pop -> ic_req next cycle, ic_pc=0x10.
REQ-041 redirect_pc=0x1003 in F_WAIT, stale ic_rdy next -> stale dropped, queue empty, next ic_pc=0x1000.
REQ-042 redirect and ic_rdy same cycle in F_WAIT -> no push, ic_req next cycle with target.
REQ-043 Full queue, push-free pop/push alternation with wrap -> FIFO order preserved across pointer wrap.
REQ-044 Reset asserted in F_WAIT, ic_rdy during reset -> dec_valid=0, next ic_pc=RESET_PC.
